hazard_unit: RTL and testbench

Pipeline sequencing controller for the 5-stage CPU. Drives the enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB latches. It handles I-cache misses, D-cache waits, load-use hazards, EX-stage control redirects and the halt drain sequence. It also keeps cycle, stall and flush performance counters for the system bus.

---
 rtl/hazard_unit.sv | 178 +++++++++++++++++
 tb/tb_hazard_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_unit.sv
// Pipeline sequencing controller for the 5-stage CPU.
// Generates the PC and pipeline-latch enable/flush controls from the hazard
// inputs and a small RUN/DWAIT/DRAIN/HALTED FSM. It also keeps cycle, stall
// and flush performance counters.
//
// Control semantics: every _en and _flush output is a same-cycle combinational
// command that the latch samples on the next rising CLK edge. When a latch sees
// both its _flush and its _en, the flush wins and the latch loads a bubble.
// While nRST is low, every control is held at 0.
module hazard_unit #(
    parameter int CNTW = 32
) (
    input  logic            CLK,
    input  logic            nRST,
    input  logic            ihit,
    input  logic            dhit,
    input  logic            mem_dren,
    input  logic            mem_dwen,
    input  logic            mem_halt,
    input  logic            ex_memread,
    input  logic [4:0]      ex_rd,
    input  logic [4:0]      id_rs,
    input  logic [4:0]      id_rt,
    input  logic            id_uses_rt,
    input  logic            ex_redirect,
    output logic            pc_en,
    output logic            ifid_en,
    output logic            idex_en,
    output logic            exmem_en,
    output logic            memwb_en,
    output logic            ifid_flush,
    output logic            idex_flush,
    output logic            exmem_flush,
    output logic            halt,
    output logic [1:0]      state,
    output logic [CNTW-1:0] cyc_cnt,
    output logic [CNTW-1:0] stall_cnt,
    output logic [CNTW-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [CNTW-1:0] CNT_ONE = {{(CNTW-1){1'b0}}, 1'b1};

    state_t cur_state;
    state_t nxt_state;

    logic dreq;
    logic dstall;
    logic loaduse;
    logic run_like;

    // Raw (ungated) controls chosen by the FSM and the priority rules.
    logic pc_en_c;
    logic ifid_en_c;
    logic idex_en_c;
    logic exmem_en_c;
    logic memwb_en_c;
    logic ifid_flush_c;
    logic idex_flush_c;
    logic exmem_flush_c;

    // A load in EX feeding rs (or rt, when ID actually reads it) needs one bubble.
    assign dreq     = mem_dren | mem_dwen;
    assign dstall   = dreq & ~dhit;
    assign loaduse  = ex_memread & (ex_rd != 5'd0) &
                      ((ex_rd == id_rs) | (id_uses_rt & (ex_rd == id_rt)));
    assign run_like = (cur_state == RUN) || (cur_state == DWAIT);

    // State register; reset drops straight back to RUN from any state.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cur_state <= RUN;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // Next-state and control selection: data stall first, then redirect,
    // fetch miss, load-use, and finally a normal advance.
    always_comb begin
        nxt_state     = cur_state;
        pc_en_c       = 1'b0;
        ifid_en_c     = 1'b0;
        idex_en_c     = 1'b0;
        exmem_en_c    = 1'b0;
        memwb_en_c    = 1'b0;
        ifid_flush_c  = 1'b0;
        idex_flush_c  = 1'b0;
        exmem_flush_c = 1'b0;
        case (cur_state)
            RUN, DWAIT: begin
                if (dstall) begin
                    // Whole pipe frozen; a HALT in MEM waits for the access to finish.
                    nxt_state = DWAIT;
                end else begin
                    nxt_state = mem_halt ? DRAIN : RUN;
                    if (ex_redirect) begin
                        // The in-flight fetch is discarded even if it has not completed.
                        pc_en_c      = 1'b1;
                        ifid_flush_c = 1'b1;
                        idex_flush_c = 1'b1;
                        exmem_en_c   = 1'b1;
                        memwb_en_c   = 1'b1;
                    end else if (!ihit || loaduse) begin
                        idex_flush_c = 1'b1;
                        exmem_en_c   = 1'b1;
                        memwb_en_c   = 1'b1;
                    end else begin
                        pc_en_c    = 1'b1;
                        ifid_en_c  = 1'b1;
                        idex_en_c  = 1'b1;
                        exmem_en_c = 1'b1;
                        memwb_en_c = 1'b1;
                    end
                end
            end
            DRAIN: begin
                // Let the HALT retire into MEM/WB and squash everything behind it.
                memwb_en_c    = 1'b1;
                exmem_flush_c = 1'b1;
                idex_flush_c  = 1'b1;
                ifid_flush_c  = 1'b1;
                nxt_state     = HALTED;
            end
            default: begin
                nxt_state = HALTED;
            end
        endcase
    end

    // Controls are forced low while reset is asserted.
    assign pc_en       = nRST & pc_en_c;
    assign ifid_en     = nRST & ifid_en_c;
    assign idex_en     = nRST & idex_en_c;
    assign exmem_en    = nRST & exmem_en_c;
    assign memwb_en    = nRST & memwb_en_c;
    assign ifid_flush  = nRST & ifid_flush_c;
    assign idex_flush  = nRST & idex_flush_c;
    assign exmem_flush = nRST & exmem_flush_c;
    assign state       = cur_state;

    // Halt flag rises on the edge that enters HALTED and stays until reset.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            halt <= 1'b0;
        end else if (nxt_state == HALTED) begin
            halt <= 1'b1;
        end
    end

    // Performance counters wrap naturally and freeze once halted.
    // A stall cycle is any RUN/DWAIT cycle where the PC holds; a redirect
    // always loads the PC, so it is never counted as a stall.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cyc_cnt   <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (cur_state != HALTED) begin
                cyc_cnt <= cyc_cnt + CNT_ONE;
            end
            if (run_like && !pc_en_c) begin
                stall_cnt <= stall_cnt + CNT_ONE;
            end
            if (run_like && ex_redirect && !dstall) begin
                flush_cnt <= flush_cnt + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: hand-computed control vectors and counter values.
// Control vector bit order: {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
//                            ifid_flush, idex_flush, exmem_flush}
module tb_hazard_unit;

    logic        CLK;
    logic        nRST;
    logic        ihit, dhit, mem_dren, mem_dwen, mem_halt;
    logic        ex_memread, id_uses_rt, ex_redirect;
    logic [4:0]  ex_rd, id_rs, id_rt;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en;
    logic        ifid_flush, idex_flush, exmem_flush;
    logic        halt;
    logic [1:0]  state;
    logic [31:0] cyc_cnt, stall_cnt, flush_cnt;

    // Narrow-counter instance used only for the wrap check.
    logic        s_pc_en, s_ifid_en, s_idex_en, s_exmem_en, s_memwb_en;
    logic        s_ifid_flush, s_idex_flush, s_exmem_flush, s_halt;
    logic [1:0]  s_state;
    logic [3:0]  s_cyc_cnt, s_stall_cnt, s_flush_cnt;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_cyc = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    localparam logic [7:0] CTL_IDLE   = 8'h00;
    localparam logic [7:0] CTL_NORMAL = 8'hF8;
    localparam logic [7:0] CTL_BUBBLE = 8'h1A;
    localparam logic [7:0] CTL_REDIR  = 8'h9E;
    localparam logic [7:0] CTL_DRAIN  = 8'h0F;

    hazard_unit #(.CNTW(32)) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_dren(mem_dren), .mem_dwen(mem_dwen), .mem_halt(mem_halt),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_redirect(ex_redirect),
        .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en),
        .exmem_en(exmem_en), .memwb_en(memwb_en),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
        .halt(halt), .state(state),
        .cyc_cnt(cyc_cnt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_unit #(.CNTW(4)) dut_small (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_dren(mem_dren), .mem_dwen(mem_dwen), .mem_halt(mem_halt),
        .ex_memread(ex_memread), .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .ex_redirect(ex_redirect),
        .pc_en(s_pc_en), .ifid_en(s_ifid_en), .idex_en(s_idex_en),
        .exmem_en(s_exmem_en), .memwb_en(s_memwb_en),
        .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush), .exmem_flush(s_exmem_flush),
        .halt(s_halt), .state(s_state),
        .cyc_cnt(s_cyc_cnt), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    // Clock and reset block.
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Watchdog so the run always ends.
    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] ctl();
        return {pc_en, ifid_en, idex_en, exmem_en, memwb_en,
                ifid_flush, idex_flush, exmem_flush};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
        chk({tag, "_cyc"},   cyc_cnt,   exp_cyc);
        chk({tag, "_stall"}, stall_cnt, exp_stall);
        chk({tag, "_flush"}, flush_cnt, exp_flush);
    endtask

    // Advance one rising edge with hand-supplied counter increments, then
    // settle just after the following falling edge.
    task automatic tick(input int dc, input int ds, input int df);
        exp_cyc   += dc;
        exp_stall += ds;
        exp_flush += df;
        @(negedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        ihit = 1'b1; dhit = 1'b0; mem_dren = 1'b0; mem_dwen = 1'b0;
        mem_halt = 1'b0; ex_memread = 1'b0; id_uses_rt = 1'b0;
        ex_redirect = 1'b0; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    endtask

    initial begin
        nRST = 1'b0;
        idle_inputs();
        #1;
        // Reset state.
        chk("rst_state", {30'd0, state}, 32'd0);
        chk("rst_halt", {31'd0, halt}, 32'd0);
        chk("rst_ctl", {24'd0, ctl()}, {24'd0, CTL_IDLE});
        chk_cnt("rst");

        @(negedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        #1;

        // 17 clean cycles: all enables on; cyc 10 midway, narrow counter wraps to 1.
        for (int i = 0; i < 17; i++) begin
            if (i == 10) chk("clean10_cyc", cyc_cnt, 32'd10);
            chk("clean_ctl", {24'd0, ctl()}, {24'd0, CTL_NORMAL});
            tick(1, 0, 0);
        end
        chk_cnt("clean17");
        chk("wrap_cyc4", {28'd0, s_cyc_cnt}, 32'd1);

        // Load-use on rs: one bubble.
        ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
        #1 chk("lu_rs_ctl", {24'd0, ctl()}, {24'd0, CTL_BUBBLE});
        tick(1, 1, 0);
        chk_cnt("lu_rs");
        // Load moved to MEM: no more hazard.
        ex_memread = 1'b0;
        #1 chk("lu_after_ctl", {24'd0, ctl()}, {24'd0, CTL_NORMAL});
        tick(1, 0, 0);
        // Load into r0 never stalls.
        ex_memread = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
        #1 chk("lu_r0_ctl", {24'd0, ctl()}, {24'd0, CTL_NORMAL});
        tick(1, 0, 0);
        chk_cnt("lu_r0");
        // Load-use on rt when rt is read.
        ex_rd = 5'd7; id_rt = 5'd7; id_rs = 5'd3; id_uses_rt = 1'b1;
        #1 chk("lu_rt_ctl", {24'd0, ctl()}, {24'd0, CTL_BUBBLE});
        tick(1, 1, 0);
        // Same registers but rt not read: no stall.
        id_uses_rt = 1'b0;
        #1 chk("lu_rt_unused_ctl", {24'd0, ctl()}, {24'd0, CTL_NORMAL});
        tick(1, 0, 0);
        chk_cnt("lu_rt");
        idle_inputs();

        // Data stall for 3 cycles, then dhit.
        mem_dren = 1'b1; dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1 chk("dstall_ctl", {24'd0, ctl()}, {24'd0, CTL_IDLE});
            tick(1, 1, 0);
            chk("dstall_state", {30'd0, state}, 32'd1);
        end
        dhit = 1'b1;
        #1 chk("dhit_ctl", {24'd0, ctl()}, {24'd0, CTL_NORMAL});
        tick(1, 0, 0);
        chk("dhit_state", {30'd0, state}, 32'd0);
        chk_cnt("dstall");
        idle_inputs();

        // Redirect beats load-use and fetch miss.
        ex_redirect = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; ihit = 1'b0;
        #1 chk("redir_ctl", {24'd0, ctl()}, {24'd0, CTL_REDIR});
        tick(1, 0, 1);
        chk_cnt("redir");
        idle_inputs();

        // Fetch miss alone.
        ihit = 1'b0;
        #1 chk("imiss_ctl", {24'd0, ctl()}, {24'd0, CTL_BUBBLE});
        tick(1, 1, 0);
        chk_cnt("imiss");
        idle_inputs();

        // HALT arriving during a data stall is deferred until dhit.
        mem_dren = 1'b1; dhit = 1'b0; mem_halt = 1'b1;
        #1 chk("halt_dstall_ctl", {24'd0, ctl()}, {24'd0, CTL_IDLE});
        tick(1, 1, 0);
        chk("halt_deferred_state", {30'd0, state}, 32'd1);
        dhit = 1'b1;
        #1 chk("halt_dhit_ctl", {24'd0, ctl()}, {24'd0, CTL_NORMAL});
        tick(1, 0, 0);
        chk("drain_state", {30'd0, state}, 32'd2);
        chk("drain_halt", {31'd0, halt}, 32'd0);
        idle_inputs();
        #1 chk("drain_ctl", {24'd0, ctl()}, {24'd0, CTL_DRAIN});
        tick(1, 0, 0);
        chk("halted_state", {30'd0, state}, 32'd3);
        chk("halted_halt", {31'd0, halt}, 32'd1);
        chk("halted_ctl", {24'd0, ctl()}, {24'd0, CTL_IDLE});
        // Counters frozen while halted, even with hazards on the inputs.
        ex_redirect = 1'b1; ihit = 1'b0;
        for (int i = 0; i < 3; i++) tick(0, 0, 0);
        chk("halted_redir_ctl", {24'd0, ctl()}, {24'd0, CTL_IDLE});
        chk_cnt("frozen");
        idle_inputs();

        // Asynchronous reset pulse from HALTED.
        nRST = 1'b0;
        exp_cyc = 0; exp_stall = 0; exp_flush = 0;
        #1;
        chk("rst2_state", {30'd0, state}, 32'd0);
        chk("rst2_halt", {31'd0, halt}, 32'd0);
        chk("rst2_ctl", {24'd0, ctl()}, {24'd0, CTL_IDLE});
        chk_cnt("rst2");
        @(negedge CLK);
        nRST = 1'b1;
        #1 chk("post_rst_ctl", {24'd0, ctl()}, {24'd0, CTL_NORMAL});
        tick(1, 0, 0);
        chk_cnt("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
